// File: rtl/my_stream_mux.sv
// my_stream_mux: 2:1 packet stream mux with round-robin arbitration,
// whole-packet lock and a one-entry registered, source-tagged output.
//
// Ports:
//   clk, reset                      clock, sync active-high reset
//   a_data/a_last/a_valid, a_ready  channel A input stream
//   b_data/b_last/b_valid, b_ready  channel B input stream
//   out_data/out_last/out_sel       registered output beat (sel 0=A, 1=B)
//   out_valid, out_ready            output handshake
module my_stream_mux #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_A = 2'd1,
    S_LOCK_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prefer_b;
  logic             w_prefer_b_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic             r_sel;
  logic             r_valid;
  logic             w_can_load;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_acc_a;
  logic             w_acc_b;

  assign w_can_load = !r_valid || out_ready;

  always_comb begin
    w_a_ready      = 1'b0;
    w_b_ready      = 1'b0;
    w_state_nxt    = r_state;
    w_prefer_b_nxt = r_prefer_b;

    // readys are forced low while reset is held
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          w_a_ready = w_can_load && a_valid
                      && (!b_valid || !r_prefer_b);
          w_b_ready = w_can_load && b_valid
                      && (!a_valid || r_prefer_b);
        end
        S_LOCK_A: w_a_ready = w_can_load;
        S_LOCK_B: w_b_ready = w_can_load;
        default: ;
      endcase
    end

    w_acc_a = a_valid && w_a_ready;
    w_acc_b = b_valid && w_b_ready;

    unique case (r_state)
      S_IDLE: begin
        if (w_acc_a && !a_last)
          w_state_nxt = S_LOCK_A;
        else if (w_acc_b && !b_last)
          w_state_nxt = S_LOCK_B;
      end
      S_LOCK_A: begin
        if (w_acc_a && a_last)
          w_state_nxt = S_IDLE;
      end
      S_LOCK_B: begin
        if (w_acc_b && b_last)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // completing a packet hands priority to the other side
    if (w_acc_a && a_last)
      w_prefer_b_nxt = 1'b1;
    if (w_acc_b && b_last)
      w_prefer_b_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prefer_b <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prefer_b <= w_prefer_b_nxt;
      if (w_acc_a) begin
        r_data  <= a_data;
        r_last  <= a_last;
        r_sel   <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_acc_b) begin
        r_data  <= b_data;
        r_last  <= b_last;
        r_sel   <= 1'b1;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_my_stream_mux.sv
// tb_my_stream_mux: randomized bench for my_stream_mux with a
// packet-level reference model and an output scoreboard.
module tb_my_stream_mux;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_data = '0;
  logic         a_last = 1'b0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [W-1:0] b_data = '0;
  logic         b_last = 1'b0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_sel;
  logic         out_valid;
  logic         out_ready = 1'b1;

  always #5 clk = ~clk;

  my_stream_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
    logic         s;
  } obeat_t;

  beat_t  qa[$];
  beat_t  qb[$];
  obeat_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   pa = 100;
  int   pb = 100;
  int   por = 100;
  logic hold_a = 1'b0;
  logic hold_b = 1'b0;
  logic hs_a = 1'b0;
  logic hs_b = 1'b0;
  int   acc_cnt_a = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus: retire beats taken at the last edge,
  // present the next ones, then note which handshakes will fire.
  task automatic step(input logic rst);
    @(negedge clk);
    if (hs_a) begin
      if (qa.size() > 0) void'(qa.pop_front());
      hold_a = 1'b0;
      acc_cnt_a++;
    end
    if (hs_b) begin
      if (qb.size() > 0) void'(qb.pop_front());
      hold_b = 1'b0;
    end
    reset = rst;
    if (qa.size() > 0 &&
        (hold_a || $urandom_range(0, 99) < pa)) begin
      a_valid = 1'b1;
      a_data  = qa[0].d;
      a_last  = qa[0].l;
      hold_a  = 1'b1;
    end else begin
      a_valid = 1'b0;
      a_data  = 16'($urandom);
      a_last  = 1'($urandom);
    end
    if (qb.size() > 0 &&
        (hold_b || $urandom_range(0, 99) < pb)) begin
      b_valid = 1'b1;
      b_data  = qb[0].d;
      b_last  = qb[0].l;
      hold_b  = 1'b1;
    end else begin
      b_valid = 1'b0;
      b_data  = 16'($urandom);
      b_last  = 1'($urandom);
    end
    out_ready = ($urandom_range(0, 99) < por);
    #3;
    hs_a = a_valid && a_ready && !reset;
    hs_b = b_valid && b_ready && !reset;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 ||
            exp_q.size() > 0 || out_valid !== 1'b0)
           && n < maxc) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0",
               exp_q.size());
    end
  endtask

  task automatic push_pkt(input logic src, input int len,
                          input logic [W-1:0] base);
    for (int j = 0; j < len; j++) begin
      if (src) qb.push_back('{d: base + W'(j), l: (j == len - 1)});
      else     qa.push_back('{d: base + W'(j), l: (j == len - 1)});
    end
  endtask

  // Reference model: who owns the output (locked source, else the
  // preferred side under contention), and the expected output register.
  int           m_lock = 0;
  logic         m_pref = 1'b0;
  logic         m_ov = 1'b0;
  logic         m_init = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_last = 1'b0;
  logic         m_sel = 1'b0;
  int           own;
  logic         can;
  logic         ea;
  logic         eb;

  always begin
    @(negedge clk);
    #4;
    if (m_init) begin
      chk("out_valid", 16'(out_valid), 16'(m_ov));
      chk("out_data",  out_data,       m_data);
      chk("out_last",  16'(out_last),  16'(m_last));
      chk("out_sel",   16'(out_sel),   16'(m_sel));
    end
    if (reset) begin
      chk("a_ready_rst", 16'(a_ready), 16'(0));
      chk("b_ready_rst", 16'(b_ready), 16'(0));
      m_lock = 0;
      m_pref = 1'b0;
      m_ov   = 1'b0;
      m_data = '0;
      m_last = 1'b0;
      m_sel  = 1'b0;
      exp_q.delete();
      m_init = 1'b1;
    end else begin
      if (m_lock != 0)
        own = m_lock;
      else if (a_valid && b_valid)
        own = m_pref ? 2 : 1;
      else if (a_valid)
        own = 1;
      else if (b_valid)
        own = 2;
      else
        own = 0;
      can = !m_ov || out_ready;
      ea = can && own == 1;
      eb = can && own == 2;
      chk("a_ready", 16'(a_ready), 16'(ea));
      chk("b_ready", 16'(b_ready), 16'(eb));
      if (ea && a_valid) begin
        exp_q.push_back('{d: a_data, l: a_last, s: 1'b0});
        m_ov = 1'b1; m_data = a_data;
        m_last = a_last; m_sel = 1'b0;
        if (a_last) begin m_lock = 0; m_pref = 1'b1; end
        else m_lock = 1;
      end else if (eb && b_valid) begin
        exp_q.push_back('{d: b_data, l: b_last, s: 1'b1});
        m_ov = 1'b1; m_data = b_data;
        m_last = b_last; m_sel = 1'b1;
        if (b_last) begin m_lock = 0; m_pref = 1'b0; end
        else m_lock = 2;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Output monitor: every beat leaving the DUT must be the oldest
  // beat the model saw accepted.
  obeat_t e;
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got beat %0h, expected none",
                 out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data,       e.d);
        chk("sb_last", 16'(out_last),  16'(e.l));
        chk("sb_sel",  16'(out_sel),   16'(e.s));
      end
    end
  end

  initial begin
    int n;
    // reset with both sources offering
    qa.push_back('{d: 16'h0011, l: 1'b1});
    qb.push_back('{d: 16'h0BB0, l: 1'b1});
    step(1'b1);
    step(1'b1);
    drain(50);

    // single source, back-to-back
    push_pkt(1'b0, 1, 16'h0011);
    push_pkt(1'b0, 1, 16'h0022);
    push_pkt(1'b0, 1, 16'h0033);
    drain(50);

    // contention, single-beat packets
    for (int i = 0; i < 4; i++) begin
      push_pkt(1'b0, 1, 16'hA000 + W'(i));
      push_pkt(1'b1, 1, 16'hB000 + W'(i));
    end
    drain(50);

    // packet lock with B waiting
    push_pkt(1'b0, 4, 16'h0001);
    push_pkt(1'b1, 1, 16'hB100);
    push_pkt(1'b1, 1, 16'hB101);
    drain(50);

    // backpressure for 3 cycles
    push_pkt(1'b0, 3, 16'h3000);
    push_pkt(1'b1, 2, 16'h4000);
    step(1'b0);
    step(1'b0);
    por = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    por = 100;
    drain(50);

    // reset mid-packet, A resumes fresh against pending B
    push_pkt(1'b0, 4, 16'hC001);
    push_pkt(1'b1, 1, 16'hD001);
    n = acc_cnt_a + 2;
    for (int i = 0; i < 20 && acc_cnt_a < n; i++) step(1'b0);
    step(1'b1);
    drain(50);

    // reset mid-packet, A abandons, B must win
    push_pkt(1'b0, 4, 16'hE001);
    push_pkt(1'b1, 1, 16'hF001);
    n = acc_cnt_a + 2;
    for (int i = 0; i < 20 && acc_cnt_a < n; i++) step(1'b0);
    qa.delete();
    hold_a = 1'b0;
    step(1'b1);
    drain(50);

    // random traffic with gaps and backpressure
    pa = 60;
    pb = 60;
    por = 70;
    for (int i = 0; i < 120; i++) begin
      push_pkt(1'b0, $urandom_range(1, 4), 16'($urandom));
      push_pkt(1'b1, $urandom_range(1, 4), 16'($urandom));
    end
    drain(5000);
    por = 100;
    drain(50);
    chk("sb_empty", 16'(exp_q.size()), 16'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/my_stream_mux.md
# my_stream_mux

Two-input to one-output packet stream multiplexer. It merges channels A and B onto a single registered output channel using valid/ready handshakes and round-robin arbitration. Each packet is granted as a whole and locked until its last beat. Every output beat carries a source tag `out_sel` (0 = A, 1 = B), so a downstream `my_dmux`-style splitter can route beats back by source.

## Interface
- `WIDTH`, 16, data width of every channel
- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `a_data`  input  WIDTH  channel A beat payload
- `a_last`  input  1  channel A final beat of packet
- `a_valid`  input  1  channel A beat present
- `a_ready`  output  1  channel A beat accepted this cycle when high with `a_valid`
- `b_data`  input  WIDTH  channel B beat payload
- `b_last`  input  1  channel B final beat of packet
- `b_valid`  input  1  channel B beat present
- `b_ready`  output  1  channel B beat accepted this cycle when high with `b_valid`
- `out_data`  output  WIDTH  registered output payload
- `out_last`  output  1  registered last flag
- `out_sel`  output  1  registered source tag (0 = A, 1 = B)
- `out_valid`  output  1  output register holds a beat
- `out_ready`  input  1  downstream accepts the beat this cycle

## Operation
- Transfer on a channel occurs when valid and ready are both high at a rising edge.
- Output is a one-entry register. `can_load = !out_valid || out_ready`.
- State machine has three states: IDLE, LOCK_A, LOCK_B. A 1-bit pointer `prefer_b` resets to 0.
- IDLE:
  - `a_ready = can_load && a_valid && (!b_valid || !prefer_b)`
  - `b_ready = can_load && b_valid && (!a_valid || prefer_b)`
  - Accepted beat with last = 0 moves to LOCK_A or LOCK_B.
  - Accepted beat with last = 1 stays in IDLE.
- LOCK_A: `a_ready = can_load`, `b_ready = 0`. Accepted A beat with last = 1 returns to IDLE. LOCK_B mirrors this for B.
- Pointer update: on acceptance of any last beat from A, set `prefer_b = 1`. On any last beat from B, set `prefer_b = 0`.
- The accepted beat loads `out_data`, `out_last` and `out_sel` at the same edge, and `out_valid` is set.
- If no beat is accepted and `out_ready` is high, `out_valid` clears. Data fields hold their last value.
- At most one of `a_ready` and `b_ready` is high in any cycle.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_sel = 0`, state IDLE, `prefer_b = 0`.
- While `reset` is high, `a_ready` and `b_ready` are 0.
- Latency: a beat accepted at edge k is visible on the output after edge k (one cycle).
- Throughput: one beat per cycle while `out_ready` is held high, including back-to-back packets and source switches.
- Backpressure: when `out_valid = 1` and `out_ready = 0`, both readys are 0 and the output holds stable.
- Simultaneous drain and load: the old beat leaves and the new beat loads at the same edge, so `out_valid` stays 1.
- In a lock state, the other channel's valid is ignored however long it waits. Each packet completion hands priority to the other side.
- Reset mid-packet: the output register clears and the state returns to IDLE. The partial packet is not resumed; the source's next beat starts arbitration fresh.
- Valid deasserting inside a locked packet (a gap) keeps the lock. No beats from the other channel are interleaved.

## Test plan
- Reset: assert `reset` for 2 cycles with both valids high. Required: all readys 0, `out_valid = 0`, `out_data = 0`, `out_sel = 0`. First grant after release goes to A.
- Single source: A sends 3 single-beat packets 0x0011, 0x0022, 0x0033 with `out_ready = 1`. Required: they appear on consecutive cycles after 1-cycle latency, `out_sel = 0`, `out_last = 1` each.
- Contention and round-robin: A and B each continuously offer 1-beat packets (A: 0xA000+n, B: 0xB000+n). Required: output alternates A0, B0, A1, B1, with `out_sel` toggling 0, 1, 0, 1.
- Packet lock: A sends a 4-beat packet 0x1..0x4 (last on 0x4) while B is valid throughout. Required: all 4 A beats are contiguous with `out_sel = 0`, then a B beat follows. `b_ready` stays 0 until A's last beat is accepted.
- Backpressure: hold `out_ready = 0` for 3 cycles with `out_valid = 1`. Required: `out_data` is stable, both readys are 0, and no beat is lost or duplicated when `out_ready` returns high.
- Reset mid-packet: assert `reset` after beat 2 of a 4-beat A packet. Required: `out_valid = 0`, state is IDLE, and a pending B beat is granted first after release only if A is not valid.
